bubblesort_stream_ctrl: RTL and testbench
=========================================

// Module: bubblesort_stream_ctrl
// PURPOSE
//  Upstream/downstream stream adapter for the scan-chained bubble-sort array.
//  - Accepts NUM words on a valid/ready input stream and shifts them into the array's scan chain.
//  - Holds the array Enable for SORT_CYCLES cycles.
//  - Shifts the sorted words back out on a valid/ready output stream.
//  - Replaces host-bus scan access with a self-sequenced streaming front/back end.
// PARAMETERS
//  WIDTH        32   data word width; equals array node width
//  NUM          4    number of registers in the scan chain (words per batch), >=2
//  SORT_CYCLES  4    cycles Enable is held high per batch, >=1
//  CWIDTH       8    counter width; must hold max(NUM, SORT_CYCLES)
// PORTS
//  Clk         in   1      rising-edge clock
//  Reset       in   1      asynchronous, active-high reset
//  InValid     in   1      input word valid
//  InData      in   WIDTH  input word
//  InReady     out  1      block can accept InData this cycle
//  OutValid    out  1      output word valid
//  OutData     out  WIDTH  output word (combinational from ScanIn)
//  OutReady    in   1      downstream accepts OutData
//  ScanOut     out  WIDTH  to chain head (first register's ScanIn)
//  ScanIn      in   WIDTH  from chain tail (last register's ScanOut)
//  ScanEnable  out  1      shift strobe to all chain registers
//  Enable      out  1      sort enable to all chain registers
//  Done        out  1      one-cycle pulse after last output handshake
// BEHAVIOUR
//  - Reset (async, any state): state=LOAD, cnt=0; InReady=0 during reset.
//    OutValid, ScanEnable, Enable and Done are 0. ScanOut=0.
//  - FSM: LOAD -> SORT -> DRAIN -> LOAD. cnt is a single shared down/up counter.
//  - LOAD: InReady=1.
//    On InValid&&InReady: ScanEnable=1 and ScanOut=InData in the same cycle (chain shifts at the edge); cnt++.
//    The NUMth accept moves to SORT with cnt=SORT_CYCLES.
//    With no InValid, the block holds; ScanEnable=0.
//  - SORT: Enable=1 every cycle; cnt-- each cycle. When cnt==1, the next state is DRAIN with cnt=NUM.
//    InReady=0, OutValid=0, ScanEnable=0. Enable is high exactly SORT_CYCLES cycles.
//  - DRAIN: OutValid=1, OutData=ScanIn (tail value, zero latency).
//    On OutValid&&OutReady: ScanEnable=1, ScanOut=0 (zero fill); cnt--.
//    The last handshake (cnt==1) pulses Done on the next cycle, enters LOAD and sets cnt=0.
//    Back-pressure: OutReady=0 holds OutData stable, with no shift.
//  - Ordering: chain is FIFO under shift; the first word loaded reaches the tail first. Output order is the array's post-sort tail-first order.
//  - Handshakes never overlap: InReady and OutValid are never both 1. ScanEnable and Enable are never both 1.
//  - Batch latency with no stalls: NUM load cycles + SORT_CYCLES + NUM drain cycles.
//  - Done pulses in the first LOAD cycle; InReady is already 1 in that cycle.
//  - Reset mid-batch: the partially loaded or sorted data is abandoned. Chain contents are not cleared by this block.
// CONFIGURATION
//  BUBBLESORT_STREAM_PERF_EN
//   - Defined: adds port CycleCount out CWIDTH+8, which holds the cycle count of the last completed batch.
//     The count runs from the first LOAD accept to the last DRAIN handshake, inclusive.
//     It saturates at all-ones, is updated when Done pulses, and resets to 0.
//   - Undefined: the port, counter and logic are absent; behaviour is otherwise identical.
// STRUCTURE
//  - bubblesort_pkg: state enum {LOAD, SORT, DRAIN} (2-bit) and default WIDTH/NUM constants.
//  - Sub-module bubblesort_stream_cnt: loadable up/down counter with zero/one flags.
//    Instantiated once and shared by all states. The FSM and output muxing stay in the top module.
// TESTING
//  - Test 1, bench uses a pass-through chain model (Enable ignored). Stream 1,2,3,4 with InValid always high and OutReady=1.
//    Expected: ScanEnable high 4 cycles, Enable high 4 cycles, then OutData 1,2,3,4 on 4 consecutive cycles, Done one cycle later.
//  - Test 2, real 4-node array connected. Load 7,3,9,1, then drain.
//    Expected: the 4 outputs are a permutation of {1,3,7,9} in the array's sorted order. Subsequent drains show zero-fill.
//  - Test 3, OutReady toggles 1,0,0,1,... during DRAIN.
//    Expected: OutData stable while OutReady=0, no ScanEnable in those cycles, 4 words delivered.
//  - Test 4, InValid gaps in LOAD (valid on cycles 0,3,4,7).
//    Expected: exactly 4 ScanEnable pulses, aligned with the accepts; SORT entered after the 4th accept.
//  - Test 5, Reset asserted asynchronously in mid-SORT (between clock edges).
//    Expected: Enable drops immediately, state=LOAD, InReady=1 after release. The next batch completes normally.
//  - Test 6, with BUBBLESORT_STREAM_PERF_EN defined.
//    Expected: stall-free batch (NUM=4, SORT_CYCLES=4) reports CycleCount=12. Adding 3 OutReady stall cycles reports 15.

Source files
------------

// File: rtl/bubblesort_pkg.sv
// -----------------------------------------------------------------------------
// bubblesort_pkg
//   Shared types and default sizes for the bubble-sort stream controller.
//   - state_t : controller phase (LOAD -> SORT -> DRAIN -> LOAD)
//   - dbg_t   : debug view of the controller (phase plus counter flags)
//   - DEF_*   : default parameter values used by the top module
// -----------------------------------------------------------------------------
package bubblesort_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SORT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    state_t state;
    logic   cnt_zero;
    logic   cnt_one;
  } dbg_t;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_NUM         = 4;
  localparam int DEF_SORT_CYCLES = 4;
  localparam int DEF_CWIDTH      = 8;

endpackage

// File: rtl/bubblesort_stream_cnt.sv
// -----------------------------------------------------------------------------
// bubblesort_stream_cnt
//   Loadable up/down counter shared by every phase of the stream controller.
//   Load has priority over increment, increment over decrement.
// Ports
//   i_clk, i_rst      clock, asynchronous active-high reset (count -> 0)
//   i_load/i_load_val synchronous load
//   i_inc, i_dec      count up / count down by one
//   o_cnt             current count
//   o_zero, o_one     count == 0 / count == 1
// -----------------------------------------------------------------------------
module bubblesort_stream_cnt #(
  parameter int CWIDTH = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [CWIDTH-1:0] i_load_val,
  input  logic              i_inc,
  input  logic              i_dec,
  output logic [CWIDTH-1:0] o_cnt,
  output logic              o_zero,
  output logic              o_one
);

  logic [CWIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (i_dec) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);
  assign o_one  = (r_cnt == CWIDTH'(1));

endmodule

// File: rtl/bubblesort_stream_ctrl.sv
// -----------------------------------------------------------------------------
// bubblesort_stream_ctrl
//   Streaming front/back end for a scan-chained bubble-sort array. A batch of
//   NUM words is shifted into the chain, the array is enabled for SORT_CYCLES
//   cycles, then the chain is shifted out (zero filled) to the output stream.
//
// Handshakes: a word moves on an input/output port in every cycle where its
//   valid and ready are both high at the rising edge. Ready never depends on
//   valid of the same port; OutValid and InReady are never high together.
//
// Ports
//   Clk, Reset          clock, asynchronous active-high reset
//   InValid/InData      input stream, InReady high only in LOAD
//   OutValid/OutData    output stream, OutData is the chain tail (ScanIn)
//   OutReady            downstream accept
//   ScanOut/ScanIn      chain head data / chain tail data
//   ScanEnable, Enable  chain shift strobe / array sort enable
//   Done                one-cycle pulse in the cycle after the last output
//   o_dbg               controller phase and counter flags
//   CycleCount          (BUBBLESORT_STREAM_PERF_EN only) cycles of the last
//                       completed batch, first accept to last output
//
// Build option: define BUBBLESORT_STREAM_PERF_EN to add the CycleCount port.
// -----------------------------------------------------------------------------
module bubblesort_stream_ctrl
  import bubblesort_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int NUM         = DEF_NUM,
  parameter int SORT_CYCLES = DEF_SORT_CYCLES,
  parameter int CWIDTH      = DEF_CWIDTH
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              InValid,
  input  logic [WIDTH-1:0]  InData,
  output logic              InReady,
  output logic              OutValid,
  output logic [WIDTH-1:0]  OutData,
  input  logic              OutReady,
  output logic [WIDTH-1:0]  ScanOut,
  input  logic [WIDTH-1:0]  ScanIn,
  output logic              ScanEnable,
  output logic              Enable,
  output logic              Done,
`ifdef BUBBLESORT_STREAM_PERF_EN
  output logic [CWIDTH+7:0] CycleCount,
`endif
  output dbg_t              o_dbg
);

  localparam logic [CWIDTH-1:0] C_LAST_LOAD = CWIDTH'(NUM - 1);
  localparam logic [CWIDTH-1:0] C_SORT      = CWIDTH'(SORT_CYCLES);
  localparam logic [CWIDTH-1:0] C_NUM       = CWIDTH'(NUM);

  state_t            r_state, w_next_state;
  logic              r_done;
  logic              w_cnt_load, w_cnt_inc, w_cnt_dec;
  logic [CWIDTH-1:0] w_cnt_load_val, w_cnt;
  logic              w_zero, w_one;
  logic              w_accept, w_last_hs;

  bubblesort_stream_cnt #(.CWIDTH(CWIDTH)) u_cnt (
    .i_clk      (Clk),
    .i_rst      (Reset),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .i_inc      (w_cnt_inc),
    .i_dec      (w_cnt_dec),
    .o_cnt      (w_cnt),
    .o_zero     (w_zero),
    .o_one      (w_one)
  );

  // Reset gates the input handshake so nothing is accepted while it is held.
  assign w_accept = (r_state == ST_LOAD) && InValid && !Reset;
  assign OutData  = ScanIn;
  assign Done     = r_done;
  assign o_dbg    = '{state: r_state, cnt_zero: w_zero, cnt_one: w_one};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_LOAD;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= w_last_hs;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_cnt_load     = 1'b0;
    w_cnt_load_val = '0;
    w_cnt_inc      = 1'b0;
    w_cnt_dec      = 1'b0;
    InReady        = 1'b0;
    OutValid       = 1'b0;
    ScanEnable     = 1'b0;
    ScanOut        = '0;
    Enable         = 1'b0;
    w_last_hs      = 1'b0;
    case (r_state)
      ST_LOAD: begin
        InReady = !Reset;
        if (w_accept) begin
          ScanEnable = 1'b1;
          ScanOut    = InData;
          if (w_cnt == C_LAST_LOAD) begin
            w_cnt_load     = 1'b1;
            w_cnt_load_val = C_SORT;
            w_next_state   = ST_SORT;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      ST_SORT: begin
        Enable = 1'b1;
        if (w_one) begin
          w_cnt_load     = 1'b1;
          w_cnt_load_val = C_NUM;
          w_next_state   = ST_DRAIN;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ST_DRAIN: begin
        OutValid = 1'b1;
        if (OutReady) begin
          // Shift the chain towards the tail, back-filling the head with zero.
          ScanEnable = 1'b1;
          if (w_one) begin
            w_cnt_load   = 1'b1;
            w_last_hs    = 1'b1;
            w_next_state = ST_LOAD;
          end else begin
            w_cnt_dec = 1'b1;
          end
        end
      end
      default: w_next_state = ST_LOAD;
    endcase
  end

`ifdef BUBBLESORT_STREAM_PERF_EN
  localparam int PW = CWIDTH + 8;

  logic [PW-1:0] r_perf_acc, w_perf_next, r_cycle_count;
  logic          w_in_batch;

  // A batch is in flight from the first accept (count leaves zero) until the
  // last drain handshake returns the controller to LOAD with count zero.
  assign w_in_batch = (r_state != ST_LOAD) || !w_zero;

  always_comb begin
    w_perf_next = r_perf_acc;
    if (w_in_batch) begin
      w_perf_next = (&r_perf_acc) ? r_perf_acc : r_perf_acc + 1'b1;
    end else if (w_accept) begin
      w_perf_next = PW'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_perf_acc    <= '0;
      r_cycle_count <= '0;
    end else begin
      r_perf_acc <= w_perf_next;
      if (w_last_hs) begin
        r_cycle_count <= w_perf_next;
      end
    end
  end

  assign CycleCount = r_cycle_count;
`endif

endmodule

// File: tb/tb_bubblesort_stream_ctrl.sv
module tb_bubblesort_stream_ctrl;
  import bubblesort_pkg::*;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int SC = 4;
  localparam int CW = 8;

  // ---------------- clock / reset / DUT ----------------
  logic         Clk = 1'b0;
  logic         Reset;
  logic         InValid, OutReady;
  logic [W-1:0] InData;
  logic         InReady, OutValid, ScanEnable, Enable, Done;
  logic [W-1:0] OutData, ScanOut, ScanIn;
  dbg_t         dbg;
`ifdef BUBBLESORT_STREAM_PERF_EN
  logic [CW+7:0] CycleCount;
`endif

  always #5 Clk = ~Clk;

  bubblesort_stream_ctrl #(.WIDTH(W), .NUM(N), .SORT_CYCLES(SC), .CWIDTH(CW)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .InValid    (InValid),
    .InData     (InData),
    .InReady    (InReady),
    .OutValid   (OutValid),
    .OutData    (OutData),
    .OutReady   (OutReady),
    .ScanOut    (ScanOut),
    .ScanIn     (ScanIn),
    .ScanEnable (ScanEnable),
    .Enable     (Enable),
    .Done       (Done),
`ifdef BUBBLESORT_STREAM_PERF_EN
    .CycleCount (CycleCount),
`endif
    .o_dbg      (dbg)
  );

  // ---------------- chain / array model ----------------
  // FIFO scan chain; with sort_mode set, each Enable cycle does one
  // odd-even transposition phase that moves smaller words towards the tail.
  logic [W-1:0] chain [N] = '{default: '0};
  logic         ph = 1'b0;
  logic         sort_mode = 1'b0;

  assign ScanIn = chain[N-1];

  always @(posedge Clk) begin
    if (ScanEnable) begin
      for (int i = N - 1; i > 0; i--) chain[i] <= chain[i-1];
      chain[0] <= ScanOut;
      ph <= 1'b0;
    end else if (Enable && sort_mode) begin
      for (int i = 0; i < N - 1; i++) begin
        if ((i[0] == ph) && (chain[i] < chain[i+1])) begin
          chain[i]   <= chain[i+1];
          chain[i+1] <= chain[i];
        end
      end
      ph <= ~ph;
    end
  end

  // ---------------- scoreboard state ----------------
  int           n_cmp = 0;
  int           n_fail = 0;
  logic [W-1:0] exp_q[$];

  logic         s_in_ready, s_out_valid, s_se, s_en, s_done;
  logic [W-1:0] s_out_data, s_scan_out;
  state_t       s_state;
  logic         last_accept, last_hs;
  logic         exp_done = 1'b0, prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  int           hs_batch = 0;
  int           tot_en = 0, tot_se = 0, tot_acc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: sample and check protocol rules at the falling edge,
  // then return just after the next rising edge for the driver.
  task automatic tick();
    logic acc, hs;
    @(negedge Clk);
    s_in_ready  = InReady;  s_out_valid = OutValid; s_se = ScanEnable;
    s_en        = Enable;   s_done      = Done;     s_out_data = OutData;
    s_scan_out  = ScanOut;  s_state     = dbg.state;
    last_accept = 1'b0;     last_hs     = 1'b0;
    if (Reset) begin
      chk("rst_in_ready", s_in_ready, 0);
      chk("rst_out_valid", s_out_valid, 0);
      chk("rst_scan_en", s_se, 0);
      chk("rst_enable", s_en, 0);
      chk("rst_done", s_done, 0);
      chk("rst_scan_out", s_scan_out, 0);
      chk("rst_state", s_state, ST_LOAD);
      hs_batch = 0; exp_done = 1'b0; prev_stall = 1'b0;
    end else begin
      acc = InValid && s_in_ready;
      hs  = s_out_valid && OutReady;
      chk("ready_valid_overlap", s_in_ready & s_out_valid, 0);
      chk("scan_enable_overlap", s_se & s_en, 0);
      chk("scan_enable", s_se, acc | hs);
      if (acc) chk("scan_out_load", s_scan_out, InData);
      if (hs)  chk("scan_out_fill", s_scan_out, 0);
      if (prev_stall && s_out_valid) chk("stall_hold", s_out_data, prev_data);
      chk("done", s_done, exp_done);
      if (s_done) chk("done_in_ready", s_in_ready, 1);
      exp_done = 1'b0;
      if (hs) begin
        hs_batch++;
        if (hs_batch == N) begin exp_done = 1'b1; hs_batch = 0; end
      end
      prev_stall = s_out_valid && !OutReady;
      prev_data  = s_out_data;
      if (s_en) tot_en++;
      if (s_se) tot_se++;
      if (acc) tot_acc++;
      last_accept = acc;
      last_hs     = hs;
    end
    @(posedge Clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Output order: load order for a plain chain, ascending when sorted.
  function automatic logic [N-1:0][W-1:0] ref_out(input logic [N-1:0][W-1:0] w, input logic srt);
    logic [W-1:0] q[$];
    for (int k = 0; k < N; k++) q.push_back(w[k]);
    if (srt) q.sort();
    for (int k = 0; k < N; k++) ref_out[k] = q[k];
  endfunction

  function automatic logic ready_pat(input int mode, input int idx);
    case (mode)
      1:       ready_pat = (idx % 3) == 0;
      2:       ready_pat = !(idx >= 1 && idx <= 3);
      3:       ready_pat = 1'($urandom_range(0, 1));
      default: ready_pat = 1'b1;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_batch(input logic [N-1:0][W-1:0] w, input int gap_mode);
    int g, n;
    for (int k = 0; k < N; k++) begin
      g = (gap_mode == 1) ? ((k % 2 == 1) ? 2 : 0) : (gap_mode == 2) ? $urandom_range(0, 2) : 0;
      repeat (g) begin InValid = 1'b0; InData = $urandom; tick(); end
      InValid = 1'b1; InData = w[k]; n = 0;
      tick(); n++;
      while (!last_accept && n < 50) begin tick(); n++; end
      if (!last_accept) chk("load_timeout", 0, 1);
    end
    InValid = 1'b0;
  endtask

  task automatic drain_batch(input int rmode, input logic [N-1:0][W-1:0] expw);
    int idx, got, n;
    logic [W-1:0] e;
    for (int k = 0; k < N; k++) exp_q.push_back(expw[k]);
    idx = 0; got = 0; n = 0;
    while (got < N && n < 200) begin
      OutReady = ready_pat(rmode, idx);
      tick(); n++;
      if (s_out_valid) begin
        idx++;
        if (last_hs) begin
          got++;
          if (exp_q.size() == 0) chk("exp_q_empty", 1, 0);
          else begin e = exp_q.pop_front(); chk("out_data", s_out_data, e); end
        end
      end
    end
    if (got < N) chk("drain_timeout", got, N);
    OutReady = 1'b0;
    tick();  // Done cycle, checked inside tick
  endtask

  task automatic run_batch(input logic [N-1:0][W-1:0] w, input logic srt,
                           input int gap_mode, input int rmode);
    int en0, se0;
    sort_mode = srt;
    en0 = tot_en; se0 = tot_se;
    load_batch(w, gap_mode);
    drain_batch(rmode, ref_out(w, srt));
    chk("enable_cycles", tot_en - en0, SC);
    chk("scan_pulses", tot_se - se0, 2 * N);
  endtask

  // ---------------- stimulus ----------------
  typedef struct packed {
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_ready;
    logic         e_in_ready;
    logic         e_se;
    logic         e_en;
    logic         e_out_valid;
    logic [W-1:0] e_out_data;
    logic         e_done;
  } row_t;

  row_t t1 [13];
  logic [N-1:0][W-1:0] w;
  int acc0, se0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; InValid = 1'b0; InData = '0; OutReady = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    tick();
    chk("post_reset_in_ready", s_in_ready, 1);
    chk("post_reset_state", s_state, ST_LOAD);

    // Test 1: pass-through chain, cycle-exact table
    for (int k = 0; k < 4; k++) t1[k]     = '{1'b1, W'(k + 1), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0};
    for (int k = 4; k < 8; k++) t1[k]     = '{1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0};
    for (int k = 8; k < 12; k++) t1[k]    = '{1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, W'(k - 7), 1'b0};
    t1[12] = '{1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1};
    sort_mode = 1'b0;
    for (int r = 0; r < 13; r++) begin
      InValid = t1[r].in_valid; InData = t1[r].in_data; OutReady = t1[r].out_ready;
      tick();
      chk($sformatf("t1[%0d].in_ready", r), s_in_ready, t1[r].e_in_ready);
      chk($sformatf("t1[%0d].scan_en", r), s_se, t1[r].e_se);
      chk($sformatf("t1[%0d].enable", r), s_en, t1[r].e_en);
      chk($sformatf("t1[%0d].out_valid", r), s_out_valid, t1[r].e_out_valid);
      if (t1[r].e_out_valid) chk($sformatf("t1[%0d].out_data", r), s_out_data, t1[r].e_out_data);
      chk($sformatf("t1[%0d].done", r), s_done, t1[r].e_done);
    end
    InValid = 1'b0; OutReady = 1'b0;

    // Test 2: sorting array, 7,3,9,1 -> 1,3,7,9, then zero-filled chain
    w[0] = 7; w[1] = 3; w[2] = 9; w[3] = 1;
    run_batch(w, 1'b1, 0, 0);
    for (int k = 0; k < N; k++) chk($sformatf("zero_fill[%0d]", k), chain[k], 0);

    // Test 3: OutReady 1,0,0,1,... during drain
    for (int k = 0; k < N; k++) w[k] = $urandom;
    run_batch(w, 1'b1, 0, 1);

    // Test 4: InValid on cycles 0,3,4,7; SORT right after the 4th accept
    for (int k = 0; k < N; k++) w[k] = $urandom;
    sort_mode = 1'b1;
    acc0 = tot_acc; se0 = tot_se;
    load_batch(w, 1);
    chk("t4_accepts", tot_acc - acc0, N);
    chk("t4_scan_pulses", tot_se - se0, N);
    tick();
    chk("t4_sort_entry_state", s_state, ST_SORT);
    chk("t4_sort_entry_enable", s_en, 1);
    drain_batch(0, ref_out(w, 1'b1));

    // Test 5: asynchronous reset in mid-SORT
    for (int k = 0; k < N; k++) w[k] = $urandom;
    load_batch(w, 0);
    tick(); tick();
    chk("t5_in_sort", s_en, 1);
    #2 Reset = 1'b1;
    #1;
    chk("t5_enable_drop", Enable, 0);
    chk("t5_state_load", dbg.state, ST_LOAD);
    chk("t5_in_ready_rst", InReady, 0);
    tick();
    #2 Reset = 1'b0;
    #1;
    chk("t5_in_ready_release", InReady, 1);
    for (int k = 0; k < N; k++) w[k] = $urandom;
    run_batch(w, 1'b1, 0, 0);

    // Randomized batches against the reference model
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < N; k++) w[k] = $urandom_range(0, 15);
      run_batch(w, 1'($urandom_range(0, 1)), 2, 3);
    end

`ifdef BUBBLESORT_STREAM_PERF_EN
    // Test 6: batch cycle counter
    for (int k = 0; k < N; k++) w[k] = $urandom;
    run_batch(w, 1'b1, 0, 0);
    chk("t6_cycles_nostall", CycleCount, 12);
    for (int k = 0; k < N; k++) w[k] = $urandom;
    run_batch(w, 1'b1, 0, 2);
    chk("t6_cycles_3stall", CycleCount, 15);
`endif

    chk("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
